// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse digit decoder: FSM states,
// the ten legal 5-element digit patterns (0 = dot, 1 = dash, first element in MSB).
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_EVAL  = 2'd3
    } state_t;

    localparam logic [4:0] PAT_0 = 5'b11111;
    localparam logic [4:0] PAT_1 = 5'b01111;
    localparam logic [4:0] PAT_2 = 5'b00111;
    localparam logic [4:0] PAT_3 = 5'b00011;
    localparam logic [4:0] PAT_4 = 5'b00001;
    localparam logic [4:0] PAT_5 = 5'b00000;
    localparam logic [4:0] PAT_6 = 5'b10000;
    localparam logic [4:0] PAT_7 = 5'b11000;
    localparam logic [4:0] PAT_8 = 5'b11100;
    localparam logic [4:0] PAT_9 = 5'b11110;

    localparam logic [3:0] ERR_CODE = 4'hE;

    // Returns {hit, digit}; a miss carries ERR_CODE in the digit field.
    function automatic logic [4:0] lookup_digit(input logic [4:0] pat);
        logic [4:0] res;
        case (pat)
            PAT_0:   res = {1'b1, 4'd0};
            PAT_1:   res = {1'b1, 4'd1};
            PAT_2:   res = {1'b1, 4'd2};
            PAT_3:   res = {1'b1, 4'd3};
            PAT_4:   res = {1'b1, 4'd4};
            PAT_5:   res = {1'b1, 4'd5};
            PAT_6:   res = {1'b1, 4'd6};
            PAT_7:   res = {1'b1, 4'd7};
            PAT_8:   res = {1'b1, 4'd8};
            PAT_9:   res = {1'b1, 4'd9};
            default: res = {1'b0, ERR_CODE};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer: out follows in only after DEBOUNCE_CYC consecutive cycles
// of the opposite level; any return to the current level restarts the count.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (in == out) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            cnt <= '0;
            out <= in;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_digit_decoder.sv
// Decodes Morse digits 0-9 from a raw key: synchronize, debounce, time marks
// and spaces, then evaluate the 5-element pattern once the inter-character gap expires.
module morse_digit_decoder
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DOT_MAX_CYC  = 10000000,
    parameter int GAP_CYC      = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       err,
    output logic [2:0] elem_count,
    output logic       busy
);

    localparam int DW = $clog2(DOT_MAX_CYC + 2);
    localparam int GW = $clog2(GAP_CYC + 1);

    logic [1:0]    sync_q;
    logic          key_d;
    state_t        state, state_next;
    logic [DW-1:0] dur_cnt;
    logic [GW-1:0] gap_cnt;
    logic [4:0]    pattern;
    logic [4:0]    lookup;
    logic          start_mark, end_mark, gap_inc, do_eval, is_dash;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], key};
    end

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk (clk),
        .rst (rst),
        .in  (sync_q[1]),
        .out (key_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Debounced level is used directly, so a press held through EVAL starts a mark on return to IDLE.
    always_comb begin
        state_next = state;
        start_mark = 1'b0;
        end_mark   = 1'b0;
        gap_inc    = 1'b0;
        do_eval    = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_d) begin
                    state_next = S_MARK;
                    start_mark = 1'b1;
                end
            end
            S_MARK: begin
                if (!key_d) begin
                    state_next = S_SPACE;
                    end_mark   = 1'b1;
                end
            end
            S_SPACE: begin
                if (key_d) begin
                    state_next = S_MARK;
                    start_mark = 1'b1;
                end else if (gap_cnt == GW'(GAP_CYC)) begin
                    state_next = S_EVAL;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            S_EVAL: begin
                state_next = S_IDLE;
                do_eval    = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign is_dash = (dur_cnt > DW'(DOT_MAX_CYC));
    assign lookup  = lookup_digit(pattern);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            pattern     <= '0;
            elem_count  <= '0;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            err         <= 1'b0;

            if (start_mark)
                dur_cnt <= DW'(1);
            else if (state == S_MARK && dur_cnt != DW'(DOT_MAX_CYC + 1))
                dur_cnt <= dur_cnt + 1'b1;

            // Elements past the fifth only bump the count, which forces rejection.
            if (end_mark) begin
                gap_cnt <= '0;
                if (elem_count < 3'd5)
                    pattern <= {pattern[3:0], is_dash};
                if (elem_count != 3'd7)
                    elem_count <= elem_count + 1'b1;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (do_eval) begin
                dur_cnt    <= '0;
                gap_cnt    <= '0;
                pattern    <= '0;
                elem_count <= '0;
                if (elem_count == 3'd5 && lookup[4]) begin
                    digit       <= lookup[3:0];
                    digit_valid <= 1'b1;
                end else begin
                    digit <= ERR_CODE;
                    err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Bench for morse_digit_decoder: directed and random characters, with expected
// {err, digit_valid, digit} results queued by a reference model and popped by a monitor.
module tb_morse_digit_decoder;

    localparam int DEB  = 4;
    localparam int DOT  = 20;
    localparam int GAP  = 40;
    localparam int W    = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic [3:0] digit;
    logic       digit_valid;
    logic       err;
    logic [2:0] elem_count;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    int         elems[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    morse_digit_decoder #(
        .DEBOUNCE_CYC(DEB),
        .DOT_MAX_CYC (DOT),
        .GAP_CYC     (GAP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .digit      (digit),
        .digit_valid(digit_valid),
        .err        (err),
        .elem_count (elem_count),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // A character is legal only with exactly five elements. Digits 1-5 are
    // d dots then dashes; digits 6-9 are (d-5) dashes then dots; 0 is five dashes.
    function automatic logic [W-1:0] model();
        int  k;
        bit  match;
        bit  want_dash;
        if (elems.size() != 5) return {1'b1, 1'b0, 4'hE};
        for (int d = 0; d < 10; d++) begin
            k = (d == 0) ? 5 : d - 5;
            match = 1'b1;
            for (int i = 0; i < 5; i++) begin
                want_dash = (d >= 1 && d <= 5) ? (i >= d) : (i < k);
                if ((elems[i] > DOT) != want_dash) match = 1'b0;
            end
            if (match) return {1'b0, 1'b1, 4'(d)};
        end
        return {1'b1, 1'b0, 4'hE};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic hold(input bit v, input int n);
        key = v;
        repeat (n) @(negedge clk);
    endtask

    // rel == 0 picks a random inter-element release.
    task automatic send_char(input int rel);
        exp_q.push_back(model());
        foreach (elems[i]) begin
            hold(1'b1, elems[i]);
            hold(1'b0, (rel == 0) ? int'($urandom_range(8, 30)) : rel);
        end
        hold(1'b0, 60);
    endtask

    function automatic int dot_len();
        return int'($urandom_range(6, 16));
    endfunction

    function automatic int dash_len();
        return int'($urandom_range(25, 40));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && (digit_valid || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got err=%0b valid=%0b digit=0x%0h, required no pulse",
                         err, digit_valid, digit);
            end else begin
                check("pulse_err_valid_digit", int'({err, digit_valid, digit}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, required finish within budget");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit busy_seen;
        int mode, d, n;

        rst = 1'b1;
        key = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digit", int'(digit), 0);
        check("reset_digit_valid", int'(digit_valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_elem_count", int'(elem_count), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        hold(1'b0, 5);

        // Digit 1, then 5, then 0
        elems = '{10, 30, 30, 30, 30};
        send_char(15);
        check("digit_after_1", int'(digit), 1);
        elems = '{10, 10, 10, 10, 10};
        send_char(15);
        elems = '{30, 30, 30, 30, 30};
        send_char(15);
        check("digit_after_0", int'(digit), 0);

        // Four elements: rejected
        elems = '{10, 10, 10, 30};
        send_char(15);
        check("digit_after_short", int'(digit), 4'hE);

        // Six dots: elem_count reaches 6 before rejection
        elems = '{10, 10, 10, 10, 10, 10};
        exp_q.push_back(model());
        foreach (elems[i]) begin
            hold(1'b1, 10);
            hold(1'b0, 15);
        end
        check("elem_count_six", int'(elem_count), 6);
        hold(1'b0, 60);
        check("digit_after_six", int'(digit), 4'hE);

        // Short glitch must never leave IDLE
        hold(1'b1, 3);
        key = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("glitch_busy", int'(busy_seen), 0);
        check("glitch_elem_count", int'(elem_count), 0);

        // A 2-cycle release inside a press: one 10-cycle dot, then four dashes -> 1
        elems = '{10, 30, 30, 30, 30};
        exp_q.push_back(model());
        hold(1'b1, 4);
        hold(1'b0, 2);
        hold(1'b1, 4);
        hold(1'b0, 15);
        check("split_press_elem_count", int'(elem_count), 1);
        for (int i = 1; i < 5; i++) begin
            hold(1'b1, 30);
            hold(1'b0, 15);
        end
        hold(1'b0, 60);
        check("digit_after_split", int'(digit), 1);

        // Reset mid-character: discard silently
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 15);
        end
        rst = 1'b1;
        #1;
        check("midreset_elem_count", int'(elem_count), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_digit", int'(digit), 0);
        check("midreset_pulses", int'({err, digit_valid}), 0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 80);

        // Randomized characters
        for (int c = 0; c < 24; c++) begin
            elems.delete();
            mode = int'($urandom_range(0, 9));
            if (mode < 7) begin
                d = int'($urandom_range(0, 9));
                for (int i = 0; i < 5; i++) begin
                    if (d >= 1 && d <= 5) elems.push_back((i >= d) ? dash_len() : dot_len());
                    else elems.push_back((i < ((d == 0) ? 5 : d - 5)) ? dash_len() : dot_len());
                end
            end else begin
                n = int'($urandom_range(1, 7));
                for (int i = 0; i < n; i++)
                    elems.push_back(($urandom_range(0, 1) == 1) ? dash_len() : dot_len());
            end
            send_char(0);
        end

        hold(1'b0, 100);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_digit_decoder.md
MORSE_DIGIT_DECODER -- requirements
Module: morse_digit_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 500000: consecutive stable cycles required to accept a key level change.
REQ-002 The block SHALL have parameter DOT_MAX_CYC, default 10000000: longest debounced press, in cycles, still classed as a dot.
REQ-003 The block SHALL have parameter GAP_CYC, default 25000000: debounced release length, in cycles, that ends a character.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port key, input, 1 bit: raw Morse key, 1 = pressed, asynchronous to clk.
REQ-007 The block SHALL have port digit, output, 4 bits: last decoded digit 0-9, or 4'hE after an error; drives the downstream 7-segment decoder.
REQ-008 The block SHALL have port digit_valid, output, 1 bit: one-cycle pulse when digit is updated with a legal digit.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle pulse when a character is rejected.
REQ-010 The block SHALL have port elem_count, output, 3 bits: elements captured in the current character, saturating at 7.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 key SHALL pass through a 2-flop synchronizer, then a debouncer whose output changes only after DEBOUNCE_CYC consecutive cycles of the opposite synchronized level.
REQ-013 The FSM SHALL have states IDLE, MARK and SPACE, plus a one-cycle EVAL state.
REQ-014 IDLE -> MARK SHALL occur on the debounced rising edge; the duration counter clears to 1.
REQ-015 In MARK the duration counter SHALL increment each cycle, saturating at DOT_MAX_CYC+1.
REQ-016 MARK -> SPACE on the debounced falling edge SHALL shift in 0 (dot) if count <= DOT_MAX_CYC, else 1 (dash), and increment elem_count.
REQ-017 Elements SHALL shift into a 5-bit pattern register with the first element ending in the MSB.
REQ-018 Elements beyond the 5th SHALL NOT alter the pattern but SHALL still increment elem_count.
REQ-019 In SPACE the gap counter SHALL increment each cycle; a debounced rising edge SHALL return the FSM to MARK with the duration counter cleared to 1.
REQ-020 SPACE -> EVAL SHALL occur when the gap counter reaches GAP_CYC.
REQ-021 The legal patterns SHALL be: 1=01111, 2=00111, 3=00011, 4=00001, 5=00000, 6=10000, 7=11000, 8=11100, 9=11110, 0=11111.
REQ-022 EVAL SHALL accept a character only when elem_count == 5 and the pattern is one of the legal patterns; digit then loads the digit value and digit_valid pulses.
REQ-023 EVAL SHALL reject every other character; digit then loads 4'hE and err pulses.
REQ-024 digit_valid and err SHALL be registered, asserted in the cycle after EVAL, and never asserted together.
REQ-025 EVAL -> IDLE SHALL clear the pattern register, elem_count and both counters; digit SHALL hold its value until the next EVAL.
REQ-026 A debounced press arriving during EVAL SHALL be ignored until IDLE; no element is lost, because debounce latency exceeds 1 cycle.
REQ-027 Overall latency SHALL be 2 sync + DEBOUNCE_CYC + GAP_CYC + 2 cycles from the raw final release to the pulse.

Reset
REQ-028 rst SHALL asynchronously force: FSM = IDLE, digit = 4'h0, digit_valid = 0, err = 0, elem_count = 0, busy = 0, synchronizer and debouncer outputs = 0, all counters and the pattern register = 0.
REQ-029 An assertion of rst mid-character SHALL discard the partial character with no err pulse.

Structure
REQ-030 A shared package morse_pkg SHALL hold the FSM state typedef, the ten 5-bit digit pattern constants, and the error code 4'hE.
REQ-031 The debouncer SHALL be a sub-module named key_debounce (parameter DEBOUNCE_CYC, ports clk, rst, in, out), instantiated once.
REQ-032 Counter widths SHALL be derived with $clog2 of their respective parameters.

Verification (bench parameters: DEBOUNCE_CYC=4, DOT_MAX_CYC=20, GAP_CYC=40)
REQ-033 Stimulus: presses of 10,30,30,30,30 cycles, each followed by a 15-cycle release, then 60 idle cycles -> required: digit=4'h1, one digit_valid pulse, err=0.
REQ-034 Stimulus: five 10-cycle dots -> required: digit=4'h5; then five 30-cycle dashes -> required: digit=4'h0.
REQ-035 Stimulus: four elements 10,10,10,30, then 60 idle cycles -> required: err pulse, digit=4'hE.
REQ-036 Stimulus: six 10-cycle dots -> required: elem_count reaches 6, then err pulse, digit=4'hE.
REQ-037 Stimulus: a 3-cycle glitch on key, and separately a 2-cycle release within a press -> required: no element counted, busy stays 0 for the glitch, and the press is timed as a single mark.
REQ-038 Stimulus: rst asserted after 3 elements -> required: immediate IDLE, elem_count=0, digit=4'h0, no pulse.
